// File: rtl/spi7001_tx.sv
// SPI7001 MiniLED driver-chain serial transmitter: valid/ready word input, mode-0 SPI out.
// Optional latch-enable pulse after each frame is built when SPI7001_TX_LE_EN is defined.
module spi7001_tx #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_cs_n,
  output logic              spi_le,
  output logic              busy,
  output logic              done
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);
`ifdef SPI7001_TX_LE_EN
  // The divider is wide enough to span the full 2*CLK_DIV latch pulse.
  localparam logic [DIV_W-1:0] LE_TC = DIV_W'(2 * CLK_DIV - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_HOLD
`ifdef SPI7001_TX_LE_EN
    , ST_LATCH
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q;
  logic [BIT_W-1:0]    bit_q;
  logic [DATA_W-2:0]   shreg_q;   // bits still to send; the MSB goes straight to mosi
  logic                last_q;
  logic                fin_q;
  logic                le_q;
  logic                accept;
  logic                div_tc;

  assign tx_ready = (state_q == ST_IDLE) || (state_q == ST_GAP);
  assign busy     = (state_q != ST_IDLE);
  assign accept   = tx_valid && tx_ready;
  assign div_tc   = (div_q == DIV_TC);

`ifdef SPI7001_TX_LE_EN
  assign spi_le = le_q;
`else
  assign spi_le = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_GAP: if (accept) state_d = ST_SHIFT;
      // Falling toggle of the last bit ends the word.
      ST_SHIFT: if (div_tc && spi_sclk && bit_q == '0) state_d = last_q ? ST_HOLD : ST_GAP;
`ifdef SPI7001_TX_LE_EN
      ST_HOLD:  if (div_tc) state_d = ST_LATCH;
      ST_LATCH: if (div_q == LE_TC) state_d = ST_IDLE;
`else
      ST_HOLD:  if (div_tc) state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so each one updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      last_q   <= 1'b0;
      fin_q    <= 1'b0;
      le_q     <= 1'b0;
      done     <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
    end else begin
      // done trails the return to IDLE by one cycle, i.e. after cs_n / spi_le settle.
      fin_q <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
      done  <= fin_q;
      if (accept) begin
        shreg_q  <= tx_data[DATA_W-2:0];
        last_q   <= tx_last;
        spi_mosi <= tx_data[DATA_W-1];
        spi_cs_n <= 1'b0;
        spi_sclk <= 1'b0;
        bit_q    <= BIT_W'(DATA_W - 1);
        div_q    <= '0;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            if (div_tc) begin
              div_q    <= '0;
              spi_sclk <= ~spi_sclk;
              if (spi_sclk && bit_q != '0) begin
                spi_mosi <= shreg_q[DATA_W-2];
                shreg_q  <= shreg_q << 1;
                bit_q    <= bit_q - BIT_W'(1);
              end
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end
          ST_HOLD: begin
            if (div_tc) begin
              div_q    <= '0;
              spi_cs_n <= 1'b1;
`ifdef SPI7001_TX_LE_EN
              le_q     <= 1'b1;
`endif
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end
`ifdef SPI7001_TX_LE_EN
          ST_LATCH: begin
            if (div_q == LE_TC) begin
              div_q <= '0;
              le_q  <= 1'b0;
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
